// File: rtl/median_window_fetch.sv
// Window fetch stage: scans a binary image in RAM and streams each full
// WINDOW_SIZE x WINDOW_SIZE neighbourhood as one contiguous pixel burst.
module median_window_fetch #(
    parameter int WINDOW_SIZE = 3,
    parameter int IMG_WIDTH   = 128,
    parameter int IMG_HEIGHT  = 128
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       hold,
    output logic       busy,
    output logic       done,
    output logic       ramReadEnable,
    output logic [7:0] ramXAddress,
    output logic [7:0] ramYAddress,
    input  logic       ramData,
    output logic       dataValid,
    output logic       dataOut,
    output logic [7:0] xAddressOut,
    output logic [7:0] yAddressOut
);

    localparam logic [7:0] WM1  = 8'(WINDOW_SIZE - 1);
    localparam logic [7:0] XMAX = 8'(IMG_WIDTH - 1);
    localparam logic [7:0] YMAX = 8'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] bx_q, bx_d;
    logic [7:0] by_q, by_d;
    logic [7:0] r_q, r_d;
    logic [7:0] c_q, c_d;
    logic       valid_q;
    logic [7:0] xout_q;
    logic [7:0] yout_q;
    logic       rd;

    always_comb begin
        state_d = state_q;
        bx_d    = bx_q;
        by_d    = by_q;
        r_d     = r_q;
        c_d     = c_q;
        rd      = 1'b0;
        done    = 1'b0;
        busy    = (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    bx_d    = WM1;
                    by_d    = WM1;
                    r_d     = 8'd0;
                    c_d     = 8'd0;
                end
            end
            FETCH: begin
                // Back-pressure only stalls before a window's first pixel
                if (!(hold && r_q == 8'd0 && c_q == 8'd0)) begin
                    rd = 1'b1;
                    if (c_q != WM1) begin
                        c_d = c_q + 8'd1;
                    end else begin
                        c_d = 8'd0;
                        if (r_q != WM1) begin
                            r_d = r_q + 8'd1;
                        end else begin
                            r_d = 8'd0;
                            if (bx_q != XMAX) begin
                                bx_d = bx_q + 8'd1;
                            end else if (by_q != YMAX) begin
                                bx_d = WM1;
                                by_d = by_q + 8'd1;
                            end else begin
                                state_d = DRAIN;
                            end
                        end
                    end
                end
            end
            DRAIN: state_d = DONE;
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            bx_q    <= 8'd0;
            by_q    <= 8'd0;
            r_q     <= 8'd0;
            c_q     <= 8'd0;
            valid_q <= 1'b0;
            xout_q  <= 8'd0;
            yout_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            r_q     <= r_d;
            c_q     <= c_d;
            valid_q <= rd;
            xout_q  <= bx_q;
            yout_q  <= by_q;
        end
    end

    assign ramReadEnable = rd;
    assign ramXAddress   = rd ? (bx_q - WM1 + c_q) : 8'd0;
    assign ramYAddress   = rd ? (by_q - WM1 + r_q) : 8'd0;
    assign dataValid     = valid_q;
    assign dataOut       = valid_q & ramData;
    assign xAddressOut   = xout_q;
    assign yAddressOut   = yout_q;

endmodule

// File: tb/tb_median_window_fetch.sv
// Directed bench for median_window_fetch on a 5x4 image with a 3x3 window;
// expected reads and pixels are queued at start and consumed by a monitor.
module tb_median_window_fetch;

    localparam int W  = 3;
    localparam int IW = 5;
    localparam int IH = 4;
    localparam int NPIX = (IW - W + 1) * (IH - W + 1) * W * W;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       hold = 1'b0;
    logic       busy;
    logic       done;
    logic       ramReadEnable;
    logic [7:0] ramXAddress;
    logic [7:0] ramYAddress;
    logic       ramData = 1'b0;
    logic       dataValid;
    logic       dataOut;
    logic [7:0] xAddressOut;
    logic [7:0] yAddressOut;

    median_window_fetch #(
        .WINDOW_SIZE(W),
        .IMG_WIDTH  (IW),
        .IMG_HEIGHT (IH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .hold         (hold),
        .busy         (busy),
        .done         (done),
        .ramReadEnable(ramReadEnable),
        .ramXAddress  (ramXAddress),
        .ramYAddress  (ramYAddress),
        .ramData      (ramData),
        .dataValid    (dataValid),
        .dataOut      (dataOut),
        .xAddressOut  (xAddressOut),
        .yAddressOut  (yAddressOut)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int mode = 0;

    function automatic logic pix(input int x, input int y);
        if (mode == 0) return 1'b1;
        return 1'(((x ^ y) & 1) != 0);
    endfunction

    always @(posedge clk)
        if (ramReadEnable) ramData <= pix(int'(ramXAddress), int'(ramYAddress));

    typedef struct { int x; int y; } rd_t;
    typedef struct { int bx; int by; int p; } dv_t;
    rd_t rdq[$];
    dv_t dvq[$];
    rd_t re;
    dv_t de;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic sb_en = 1'b0;
    int first_rd, last_rd, first_dv, last_dv, dv_cnt;
    int done_cnt, done_cyc, busy_fall, bursts;
    int first_tx, first_ty;
    logic done_busy;
    logic busy_prev = 1'b0;
    logic dv_prev = 1'b0;
    int start_edge = 0;

    task automatic clear_stats();
        first_rd  = -1;
        last_rd   = -1;
        first_dv  = -1;
        last_dv   = -1;
        dv_cnt    = 0;
        done_cnt  = 0;
        done_cyc  = -1;
        busy_fall = -1;
        bursts    = 0;
        first_tx  = -1;
        first_ty  = -1;
        done_busy = 1'b0;
    endtask

    always @(negedge clk) begin
        if (ramReadEnable) begin
            if (first_rd < 0) first_rd = cyc;
            last_rd = cyc;
            if (sb_en) begin
                check("rd_expected", rdq.size() != 0, 1);
                if (rdq.size() != 0) begin
                    re = rdq.pop_front();
                    check("rd_x", ramXAddress, re.x);
                    check("rd_y", ramYAddress, re.y);
                end
            end
        end
        if (dataValid) begin
            if (first_dv < 0) begin
                first_dv = cyc;
                first_tx = int'(xAddressOut);
                first_ty = int'(yAddressOut);
            end
            if (!dv_prev) bursts++;
            last_dv = cyc;
            dv_cnt++;
            if (sb_en) begin
                check("dv_expected", dvq.size() != 0, 1);
                if (dvq.size() != 0) begin
                    de = dvq.pop_front();
                    check("data", dataOut, de.p);
                    check("tag_x", xAddressOut, de.bx);
                    check("tag_y", yAddressOut, de.by);
                end
            end
        end
        dv_prev = dataValid;
        if (done) begin
            done_cnt++;
            done_cyc  = cyc;
            done_busy = busy;
        end
        if (busy_prev && !busy) busy_fall = cyc;
        busy_prev = busy;
    end

    task automatic push_frame();
        for (int by = W - 1; by < IH; by++)
            for (int bx = W - 1; bx < IW; bx++)
                for (int r = 0; r < W; r++)
                    for (int c = 0; c < W; c++) begin
                        rd_t a;
                        dv_t d;
                        a.x  = bx - (W - 1) + c;
                        a.y  = by - (W - 1) + r;
                        d.bx = bx;
                        d.by = by;
                        d.p  = int'(pix(a.x, a.y));
                        rdq.push_back(a);
                        dvq.push_back(d);
                    end
    endtask

    task automatic do_start();
        @(posedge clk);
        #1;
        start = 1'b1;
        start_edge = cyc + 1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (busy_fall < 0 && n < bound) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic frame_checks(input string tag, input int gaps);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_pix_cnt"}, dv_cnt, NPIX);
        check({tag, "_gaps"}, last_dv - first_dv + 1 - dv_cnt, gaps);
        check({tag, "_rdq_left"}, rdq.size(), 0);
        check({tag, "_dvq_left"}, dvq.size(), 0);
        check({tag, "_busy_fall"}, busy_fall, done_cyc + 1);
    endtask

    initial begin
        clear_stats();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rre", ramReadEnable, 0);
        check("rst_dv", dataValid, 0);
        check("rst_ramx", ramXAddress, 0);
        check("rst_ramy", ramYAddress, 0);
        check("rst_xout", xAddressOut, 0);
        check("rst_yout", yAddressOut, 0);
        check("rst_dout", dataOut, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // all-ones image, free running
        mode = 0;
        clear_stats();
        push_frame();
        sb_en = 1'b1;
        do_start();
        wait_done(300);
        frame_checks("ones", 0);
        check("ones_first_rd", first_rd, start_edge);
        check("ones_first_dv", first_dv, start_edge + 1);
        check("ones_last_dv", last_dv, last_rd + 1);
        check("ones_done_cyc", done_cyc, last_rd + 2);
        check("ones_done_busy", done_busy, 1);
        check("ones_bursts", bursts, 1);

        // checker image, with a stray start during FETCH
        mode = 1;
        clear_stats();
        push_frame();
        do_start();
        goto(start_edge + 20);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(300);
        frame_checks("xor", 0);
        check("xor_done_cyc", done_cyc, last_rd + 2);

        // 3-cycle hold at window 2 boundary, 1-cycle hold mid window 3
        clear_stats();
        push_frame();
        do_start();
        goto(start_edge + 9);
        hold = 1'b1;
        goto(start_edge + 12);
        hold = 1'b0;
        goto(start_edge + 25);
        hold = 1'b1;
        goto(start_edge + 26);
        hold = 1'b0;
        wait_done(300);
        frame_checks("hold", 3);
        check("hold_bursts", bursts, 2);
        check("hold_w2_first_rd_gap", first_rd, start_edge);

        // reset in the middle of window 3, then a clean restart
        clear_stats();
        push_frame();
        do_start();
        goto(start_edge + 22);
        sb_en = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mrst_busy", busy, 0);
        check("mrst_dv", dataValid, 0);
        check("mrst_rre", ramReadEnable, 0);
        check("mrst_done", done, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        rdq.delete();
        dvq.delete();
        clear_stats();
        push_frame();
        sb_en = 1'b1;
        do_start();
        wait_done(300);
        frame_checks("restart", 0);
        check("restart_tag_x", first_tx, W - 1);
        check("restart_tag_y", first_ty, W - 1);
        check("restart_first_dv", first_dv, start_edge + 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/median_window_fetch.md
# median_window_fetch

Upstream stage of the binary median filter. Scans a binary image held in a synchronous-read RAM and streams every full WINDOW_SIZE×WINDOW_SIZE neighbourhood to the median stage as one uninterrupted burst of WINDOW_SIZE² single-bit pixels. Each burst is tagged with the coordinates of the window's bottom-right pixel. The median stage counts pixels under `dataValid` and subtracts the centre offset from that tag.

## Interface
- WINDOW_SIZE, 3, window edge length; odd, ≥3
- IMG_WIDTH, 128, image width in pixels; WINDOW_SIZE ≤ IMG_WIDTH ≤ 256
- IMG_HEIGHT, 128, image height in pixels; WINDOW_SIZE ≤ IMG_HEIGHT ≤ 256
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse to begin a frame scan; ignored while busy
- hold  in  1  back-pressure; honoured only at window boundaries
- busy  out  1  high from the cycle after an accepted start through the done cycle
- done  out  1  one-cycle pulse after the last pixel of the frame
- ramReadEnable  out  1  read strobe to image RAM
- ramXAddress  out  8  RAM column address
- ramYAddress  out  8  RAM row address
- ramData  in  1  RAM read data; valid exactly 1 cycle after ramReadEnable
- dataValid  out  1  pixel strobe to median stage
- dataOut  out  1  pixel value, qualified by dataValid
- xAddressOut  out  8  bottom-right x of the current window, qualified by dataValid
- yAddressOut  out  8  bottom-right y of the current window, qualified by dataValid

## Operation
- Reset values: all outputs are 0 and the state is IDLE.
- Internal counters:
  - window bottom-right (bx, by), with bx ∈ [WINDOW_SIZE−1, IMG_WIDTH−1] and by ∈ [WINDOW_SIZE−1, IMG_HEIGHT−1]
  - in-window row r and column c, each ∈ [0, WINDOW_SIZE−1]
- Only windows lying fully inside the image are emitted. Window count N = (IMG_WIDTH−WINDOW_SIZE+1)·(IMG_HEIGHT−WINDOW_SIZE+1). Total pixels = N·WINDOW_SIZE².
- FSM states:
  - IDLE: start=1 → FETCH. Load bx=by=WINDOW_SIZE−1 and r=c=0.
  - FETCH: issue one read per cycle.
    - Read address: ramXAddress = bx−(WINDOW_SIZE−1)+c, ramYAddress = by−(WINDOW_SIZE−1)+r. Window order is row-major (c fastest).
    - After c=r=WINDOW_SIZE−1: bx advances by 1. When bx=IMG_WIDTH−1, bx wraps to WINDOW_SIZE−1 and by increments.
    - After the last pixel of window (IMG_WIDTH−1, IMG_HEIGHT−1) → DRAIN.
  - DRAIN: no read; one cycle → DONE.
  - DONE: done=1 for one cycle → IDLE.
- Hold rule:
  - If hold=1 in FETCH when r=c=0, no read is issued and all counters freeze.
  - hold is ignored at any other (r, c). A window burst therefore never breaks, because the median stage clears its count when dataValid drops.
- Output alignment: dataValid, xAddressOut and yAddressOut are the ramReadEnable, bx and by values registered one cycle. dataOut = ramData combinationally.
- When dataValid=0, dataOut, xAddressOut and yAddressOut are don't-care. The bench checks them only when qualified.
- Address arithmetic is 8-bit unsigned. Subtractions never underflow, because bx, by ≥ WINDOW_SIZE−1.
- start arriving during FETCH, DRAIN or DONE is dropped; it is not queued.
- reset mid-scan: state goes to IDLE and all outputs to 0 on the next edge. The in-flight RAM read is discarded.

## Timing
- start sampled at edge 0 → busy=1 and first ramReadEnable at cycle 1 → first dataValid at cycle 2.
- With hold=0 throughout, dataValid stays high for exactly N·WINDOW_SIZE² consecutive cycles.
- Last read at cycle T (the final FETCH cycle); the next cycle is DRAIN. Last dataValid at T+1 (DRAIN). done=1 and busy=1 at T+2; busy=0 at T+3.
- A new start is accepted at T+3 (IDLE).
- Each asserted hold cycle at a window boundary inserts one dataValid=0 gap between bursts.
- Burst length is always exactly WINDOW_SIZE².

## Test plan
- Params 3/5/4, all-ones RAM, single start → 6 bursts of 9 dataValid cycles, contiguous (54 cycles), dataOut=1 throughout. Tags in order: (2,2),(3,2),(4,2),(2,3),(3,3),(4,3). done pulse 2 cycles after the last read.
- Params 3/5/4, RAM pixel = x XOR y bit0 → first burst dataOut = 0,1,0,1,0,1,0,1,0 with read addresses (0,0),(1,0),(2,0),(0,1)…(2,2).
- hold=1 for 3 cycles starting at the first pixel-0 slot of window 2 → exactly 3 dataValid=0 cycles between bursts 1 and 2. Total pixel count still 54.
- hold pulsed at in-window pixel 4 → ignored; the burst stays 9 contiguous cycles.
- reset asserted mid-burst of window 3 → next cycle busy=0, dataValid=0, ramReadEnable=0. A subsequent start restarts from tag (2,2).
- start pulsed again during FETCH → no effect. Exactly one done pulse; busy drops one cycle after done.
